// File: rtl/ft232h_arb_pkg.sv
// Shared state encoding, header layout and helpers for the FT232H TX arbiter.
package ft232h_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_HDR_ID  = 3'd1;
  localparam arb_state_t ST_HDR_LEN = 3'd2;
  localparam arb_state_t ST_PAYLOAD = 3'd3;
  localparam arb_state_t ST_CKSUM   = 3'd4;
  localparam arb_state_t ST_GAP     = 3'd5;

  localparam int unsigned HDR_BYTES   = 3;
  localparam int unsigned CKSUM_BYTES = 1;

  // Header ID byte: channel number in the low nibble, upper nibble zero.
  localparam int unsigned ID_CH_W  = 4;
  localparam int unsigned ID_PAD_W = 8 - ID_CH_W;

  function automatic logic [7:0] hdr_id(input logic [ID_CH_W-1:0] ch);
    return {{ID_PAD_W{1'b0}}, ch};
  endfunction

  function automatic logic [7:0] min_burst(input logic [31:0] avail, input logic [7:0] max_burst);
    return (avail > 32'(max_burst)) ? max_burst : avail[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set req at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = (32'(ptr) + unsigned'(i)) % N;
      if (req[IW'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ft232h_tx_arbiter.sv
// Round-robin packetiser sharing the FT232H TX FIFO between N_CH producers.
// Define FT232H_ARB_CHECKSUM_EN to append an XOR checksum byte to every packet.
module ft232h_tx_arbiter
  import ft232h_arb_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned CNT_W     = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [N_CH*CNT_W-1:0] ch_avail_in,
  input  logic [N_CH*8-1:0]     ch_data_in,
  output logic [N_CH-1:0]       ch_pop_out,
  input  logic [15:0]           remaining_space_in,
  output logic [7:0]            fifo_data_out,
  output logic                  fifo_data_valid_out,
  output logic                  busy_out
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef FT232H_ARB_CHECKSUM_EN
  localparam int unsigned OVH = HDR_BYTES + CKSUM_BYTES;
`else
  localparam int unsigned OVH = HDR_BYTES;
`endif

  arb_state_t    state, state_d;
  logic [IW-1:0] gnt, gnt_d, rr_ptr, rr_d, arb_idx;
  logic [7:0]    n_len, n_d, cnt, cnt_d, data_d;
  logic          valid_d, arb_valid;
  logic [7:0]    burst [N_CH];
  logic [7:0]    head  [N_CH];
  logic [N_CH-1:0] req;
`ifdef FT232H_ARB_CHECKSUM_EN
  logic [7:0]    csum, csum_d;
`endif

  // A channel requests only if it has data and its whole packet fits right now.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      burst[k] = min_burst(32'(ch_avail_in[k*CNT_W +: CNT_W]), 8'(MAX_BURST));
      head[k]  = ch_data_in[k*8 +: 8];
      req[k]   = (ch_avail_in[k*CNT_W +: CNT_W] != '0) &&
                 ({1'b0, remaining_space_in} >= (17'(burst[k]) + 17'(OVH)));
    end
  end

  rr_arbiter #(.N(N_CH)) u_rr (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    n_d     = n_len;
    cnt_d   = cnt;
    rr_d    = rr_ptr;
    data_d  = fifo_data_out;
    valid_d = 1'b0;
`ifdef FT232H_ARB_CHECKSUM_EN
    csum_d  = csum;
`endif
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d   = arb_idx;
          n_d     = burst[arb_idx];
          rr_d    = IW'((32'(arb_idx) + 32'd1) % N_CH);
          data_d  = SYNC_BYTE;
          valid_d = 1'b1;
          state_d = ST_HDR_ID;
        end
      end
      ST_HDR_ID: begin
        data_d  = hdr_id(ID_CH_W'(gnt));
        valid_d = 1'b1;
`ifdef FT232H_ARB_CHECKSUM_EN
        csum_d  = hdr_id(ID_CH_W'(gnt));
`endif
        state_d = ST_HDR_LEN;
      end
      ST_HDR_LEN: begin
        data_d  = n_len;
        valid_d = 1'b1;
        cnt_d   = n_len;
`ifdef FT232H_ARB_CHECKSUM_EN
        csum_d  = csum ^ n_len;
`endif
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data_d  = head[gnt];
        valid_d = 1'b1;
        cnt_d   = cnt - 8'd1;
`ifdef FT232H_ARB_CHECKSUM_EN
        csum_d  = csum ^ head[gnt];
        if (cnt == 8'd1) state_d = ST_CKSUM;
`else
        if (cnt == 8'd1) state_d = ST_GAP;
`endif
      end
`ifdef FT232H_ARB_CHECKSUM_EN
      ST_CKSUM: begin
        data_d  = csum;
        valid_d = 1'b1;
        state_d = ST_GAP;
      end
`endif
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop is decoded from the state register so an async reset drops it at once.
  always_comb begin
    ch_pop_out = '0;
    if (state == ST_PAYLOAD) ch_pop_out[gnt] = 1'b1;
  end

  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state               <= ST_IDLE;
      gnt                 <= '0;
      rr_ptr              <= '0;
      n_len               <= '0;
      cnt                 <= '0;
      fifo_data_out       <= '0;
      fifo_data_valid_out <= 1'b0;
`ifdef FT232H_ARB_CHECKSUM_EN
      csum                <= '0;
`endif
    end else begin
      state               <= state_d;
      gnt                 <= gnt_d;
      rr_ptr              <= rr_d;
      n_len               <= n_d;
      cnt                 <= cnt_d;
      fifo_data_out       <= data_d;
      fifo_data_valid_out <= valid_d;
`ifdef FT232H_ARB_CHECKSUM_EN
      csum                <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_ft232h_tx_arbiter.sv
// Directed self-checking bench for ft232h_tx_arbiter (4 channels, MAX_BURST=64).
module tb_ft232h_tx_arbiter;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned MAX_BURST = 64;
  localparam int unsigned CNT_W     = 12;
`ifdef FT232H_ARB_CHECKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif

  logic                  clk_in = 1'b0;
  logic                  reset_in;
  logic [N_CH*CNT_W-1:0] ch_avail_in;
  logic [N_CH*8-1:0]     ch_data_in;
  logic [N_CH-1:0]       ch_pop_out;
  logic [15:0]           remaining_space_in;
  logic [7:0]            fifo_data_out;
  logic                  fifo_data_valid_out;
  logic                  busy_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int unsigned total  [N_CH] = '{default: 0};
  int unsigned popped [N_CH] = '{default: 0};
  bit keep3 = 1'b0;
  byte unsigned cap[$];
  int           stamp[$];
  byte unsigned exp_q[$];

  ft232h_tx_arbiter #(
    .N_CH(N_CH), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .ch_avail_in         (ch_avail_in),
    .ch_data_in          (ch_data_in),
    .ch_pop_out          (ch_pop_out),
    .remaining_space_in  (remaining_space_in),
    .fifo_data_out       (fifo_data_out),
    .fifo_data_valid_out (fifo_data_valid_out),
    .busy_out            (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Producer FIFO model: head byte of channel k at index i is k*64+i.
  function automatic byte unsigned dbyte(int unsigned k, int unsigned i);
    return 8'(k * 64 + i);
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_avail_in[k*CNT_W +: CNT_W] = keep3 ? CNT_W'(3) : CNT_W'(total[k] - popped[k]);
      ch_data_in[k*8 +: 8]          = dbyte(k, popped[k]);
    end
  end

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N_CH; k++) popped[k] <= popped[k] + 32'(ch_pop_out[k]);
  end

  always @(negedge clk_in) begin
    if (fifo_data_valid_out) begin
      cap.push_back(fifo_data_out);
      stamp.push_back(cyc);
    end
  end

  function automatic void push_pkt(int unsigned ch, int unsigned len, int unsigned first);
    byte unsigned cs;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(ch));
    exp_q.push_back(8'(len));
    cs = 8'(ch) ^ 8'(len);
    for (int unsigned i = 0; i < len; i++) begin
      exp_q.push_back(dbyte(ch, first + i));
      cs ^= dbyte(ch, first + i);
    end
    if (CK != 0) exp_q.push_back(cs);
  endfunction

  task automatic clear_cap();
    cap.delete();
    stamp.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (fifo_data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fifo_data_valid_out); end
    checks++;
    if (fifo_data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", fifo_data_out); end
    checks++;
    if (ch_pop_out !== 4'b0000) begin errors++; $display("FAIL reset_pop got=%b exp=0000", ch_pop_out); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  task automatic test_single();
    int c0;
    int unsigned p1, p0;
    @(negedge clk_in); #1;
    clear_cap();
    c0 = cyc;
    p1 = popped[1];
    p0 = popped[0];
    remaining_space_in = 16'd2048;
    total[1] += 5;
    repeat (20) @(negedge clk_in); #1;
    push_pkt(1, 5, p1);
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL single_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
    checks++;
    if (stamp.size() == 0 || stamp[0] != c0 + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", (stamp.size() != 0) ? stamp[0] : -1, c0 + 1); end
    for (int i = 1; i < stamp.size(); i++) begin
      checks++;
      if (stamp[i] != stamp[0] + i) begin errors++; $display("FAIL single_consec[%0d] got=%0d exp=%0d", i, stamp[i], stamp[0] + i); end
    end
    checks++;
    if (popped[1] - p1 != 5) begin errors++; $display("FAIL single_pops got=%0d exp=5", popped[1] - p1); end
    checks++;
    if (popped[0] != p0) begin errors++; $display("FAIL single_other_pops got=%0d exp=%0d", popped[0], p0); end
  endtask

  task automatic test_burst_cap();
    int unsigned p0, idx;
    int unsigned lens [5] = '{64, 64, 64, 64, 44};
    int off;
    @(negedge clk_in); #1;
    clear_cap();
    p0 = popped[0];
    total[0] += 300;
    repeat (400) @(negedge clk_in); #1;
    idx = p0;
    foreach (lens[p]) begin
      push_pkt(0, lens[p], idx);
      idx += lens[p];
    end
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL burst_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL burst_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
    // Exactly one idle sample between the last byte of a packet and the next SYNC.
    off = 0;
    for (int p = 0; p < 4; p++) begin
      off += 3 + int'(lens[p]) + int'(CK);
      checks++;
      if (off >= stamp.size() || stamp[off] != stamp[off-1] + 2) begin
        errors++; $display("FAIL burst_gap[%0d] got=%0d exp=%0d", p, (off < stamp.size()) ? stamp[off] - stamp[off-1] : -1, 2);
      end
    end
    checks++;
    if (popped[0] - p0 != 300) begin errors++; $display("FAIL burst_pops got=%0d exp=300", popped[0] - p0); end
  endtask

  task automatic test_round_robin();
    int n;
    int unsigned plen;
    plen = 6 + CK;
    do_reset();
    @(negedge clk_in); #1;
    clear_cap();
    keep3 = 1'b1;
    n = 0;
    while (cap.size() < 8 * plen && n < 200) begin @(negedge clk_in); #1; n++; end
    n = 0;
    while (busy_out && n < 20) begin @(negedge clk_in); #1; n++; end
    keep3 = 1'b0;
    for (int k = 0; k < N_CH; k++) total[k] = popped[k];
    checks++;
    if (cap.size() < 8 * plen || busy_out) begin
      errors++; $display("FAIL rr_timeout got=%0d bytes exp>=%0d", cap.size(), 8 * plen);
    end else begin
      for (int p = 0; p < 8; p++) begin
        checks++;
        if (cap[p*plen] !== 8'hA5 || cap[p*plen+1] !== 8'(p % 4) || cap[p*plen+2] !== 8'd3) begin
          errors++; $display("FAIL rr_grant[%0d] got=%h/%h/%h exp=a5/%h/03", p, cap[p*plen], cap[p*plen+1], cap[p*plen+2], 8'(p % 4));
        end
      end
    end
    repeat (5) @(negedge clk_in);
  endtask

  task automatic test_backpressure();
    int unsigned p0, p2;
    do_reset();
    @(negedge clk_in); #1;
    clear_cap();
    p0 = popped[0];
    p2 = popped[2];
    remaining_space_in = 16'd7;
    total[0] += 10;
    total[2] += 2;
    repeat (30) @(negedge clk_in); #1;
    push_pkt(2, 2, p2);
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL bp_skip_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_skip_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
    checks++;
    if (popped[0] != p0) begin errors++; $display("FAIL bp_ch0_pops got=%0d exp=%0d", popped[0], p0); end
    clear_cap();
    remaining_space_in = 16'd4;
    repeat (20) @(negedge clk_in); #1;
    checks++;
    if (cap.size() != 0) begin errors++; $display("FAIL bp_space4 got=%0d bytes exp=0", cap.size()); end
    remaining_space_in = 16'(12 + CK);
    repeat (20) @(negedge clk_in); #1;
    checks++;
    if (cap.size() != 0) begin errors++; $display("FAIL bp_one_short got=%0d bytes exp=0", cap.size()); end
    // Exact fit grants; dropping space mid-packet must not stall the committed packet.
    remaining_space_in = 16'(13 + CK);
    @(negedge clk_in); #1;
    checks++;
    if (cap.size() != 1 || cap[0] !== 8'hA5) begin errors++; $display("FAIL bp_exact_fit got=%0d bytes exp=1", cap.size()); end
    remaining_space_in = 16'd0;
    repeat (30) @(negedge clk_in); #1;
    push_pkt(0, 10, p0);
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL bp_fit_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_fit_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
    remaining_space_in = 16'd2048;
  endtask

  task automatic test_reset_mid_payload();
    int n;
    int unsigned p2, p3;
    do_reset();
    @(negedge clk_in); #1;
    clear_cap();
    p2 = popped[2];
    p3 = popped[3];
    total[2] += 8;
    n = 0;
    while (cap.size() < 5 && n < 50) begin @(negedge clk_in); #1; n++; end
    checks++;
    if (cap.size() != 5 || ch_pop_out !== 4'b0100) begin
      errors++; $display("FAIL rst_mid_setup got=%0d bytes pop=%b exp=5 bytes pop=0100", cap.size(), ch_pop_out);
    end
    total[3] += 1;
    #2 reset_in = 1'b1;
    #1;
    checks++;
    if (fifo_data_valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", fifo_data_valid_out); end
    checks++;
    if (ch_pop_out !== 4'b0000) begin errors++; $display("FAIL rst_mid_pop got=%b exp=0000", ch_pop_out); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy_out); end
    @(negedge clk_in);
    reset_in = 1'b0;
    clear_cap();
    checks++;
    if (popped[2] - p2 != 2) begin errors++; $display("FAIL rst_mid_pops got=%0d exp=2", popped[2] - p2); end
    // rr_ptr back at 0 puts ch2 ahead of ch3.
    repeat (30) @(negedge clk_in); #1;
    push_pkt(2, 6, p2 + 2);
    push_pkt(3, 1, p3);
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL rst_after_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_after_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
  endtask

`ifdef FT232H_ARB_CHECKSUM_EN
  task automatic test_checksum();
    int unsigned p3;
    do_reset();
    @(negedge clk_in); #1;
    clear_cap();
    p3 = popped[3];
    remaining_space_in = 16'd5;
    total[3] += 2;
    repeat (15) @(negedge clk_in); #1;
    checks++;
    if (cap.size() != 0) begin errors++; $display("FAIL cksum_ovh_hold got=%0d bytes exp=0", cap.size()); end
    remaining_space_in = 16'd6;
    repeat (15) @(negedge clk_in); #1;
    push_pkt(3, 2, p3);
    checks++;
    if (cap.size() != exp_q.size()) begin errors++; $display("FAIL cksum_count got=%0d exp=%0d", cap.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= cap.size() || cap[i] !== exp_q[i]) begin
        errors++; $display("FAIL cksum_byte[%0d] got=%h exp=%h", i, (i < cap.size()) ? cap[i] : 8'h00, exp_q[i]);
      end
    end
    remaining_space_in = 16'd2048;
  endtask
`endif

  initial begin
    reset_in           = 1'b1;
    remaining_space_in = 16'd2048;
    test_reset();
    test_single();
    test_burst_cap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_payload();
`ifdef FT232H_ARB_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
